// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, NZCV bit positions and the result-stage entry layout.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 3;
    localparam int unsigned NZCV_W    = 4;
    localparam int unsigned OP_W      = 3;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SLL = 3'd1,
        ALU_SRL = 3'd2,
        ALU_XOR = 3'd3,
        ALU_OR  = 3'd4,
        ALU_NOT = 3'd5,
        ALU_AND = 3'd6,
        ALU_SUB = 3'd7
    } alu_op_t;

    // Entry layout at the default ALU width; the stage rebuilds it for its own WIDTH.
    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [NZCV_W-1:0]    flags;
    } alu_entry_t;

    // Only the adder/subtractor produce meaningful carry and overflow.
    function automatic logic op_sets_arith_flags(alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_skid_fifo2.sv
// Two-entry FIFO with valid/ready semantics and synchronous reset; head is read straight from storage.
module alu_skid_fifo2 #(
    parameter int unsigned DW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic          full_o,
    output logic [DW-1:0] data_o
);

    localparam int unsigned CNT_W = 2;

    logic [DW-1:0]    mem_q [2];
    logic [DW-1:0]    mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push_i && (count_q != CNT_W'(2));
        do_pop   = pop_i && (count_q != CNT_W'(0));

        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != CNT_W'(0));
    assign full_o  = (count_q == CNT_W'(2));
    assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU: buffers result + NZCV snapshot in a 2-entry skid FIFO
// and owns the architectural flag register whose carry feeds back into the ALU.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_c,
    input  logic              in_v,
    input  logic              in_flag_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [NZCV_W-1:0] out_flags,
    output logic [NZCV_W-1:0] flags_q,
    output logic              carry_fb
);

    localparam int unsigned ENTRY_W = WIDTH + NZCV_W;

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [NZCV_W-1:0] flags;
    } entry_t;

    alu_op_t           op;
    logic              accept;
    logic              fifo_full;
    logic [NZCV_W-1:0] flags_upd;
    logic [NZCV_W-1:0] snapshot;
    logic [NZCV_W-1:0] flags_d;
    entry_t            push_entry;
    entry_t            head_entry;

    assign in_ready = !rst && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign op       = alu_op_t'(in_op);

    // Logic ops derive N/Z from the result locally; C and V carry over from the register.
    always_comb begin
        flags_upd = flags_q;
        snapshot  = flags_q;
        flags_d   = flags_q;

        if (op_sets_arith_flags(op)) begin
            flags_upd = {in_n, in_z, in_c, in_v};
        end else begin
            flags_upd[FLAG_N] = in_result[WIDTH-1];
            flags_upd[FLAG_Z] = (in_result == WIDTH'(0));
        end

        if (in_flag_en) begin
            snapshot = flags_upd;
        end
        if (accept && in_flag_en) begin
            flags_d = flags_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign carry_fb = flags_q[FLAG_C];

    assign push_entry.result = in_result;
    assign push_entry.flags  = snapshot;

    alu_skid_fifo2 #(
        .DW (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .data_i  (push_entry),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .full_o  (fifo_full),
        .data_o  (head_entry)
    );

    assign out_result = head_entry.result;
    assign out_flags  = head_entry.flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue-based reference model checked every cycle.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_result;
    logic [2:0] in_op;
    logic       in_n, in_z, in_c, in_v;
    logic       in_flag_en;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] flags_q;
    logic       carry_fb;

    int errors = 0;
    int checks = 0;

    alu_result_stage #(.WIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_op      (in_op),
        .in_n       (in_n),
        .in_z       (in_z),
        .in_c       (in_c),
        .in_v       (in_v),
        .in_flag_en (in_flag_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .flags_q    (flags_q),
        .carry_fb   (carry_fb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of entries plus an NZCV register, following the flag rules directly.
    alu_entry_t mq[$];
    logic [3:0] mflags = 4'h0;
    bit         live   = 1'b0;
    bit         fresh  = 1'b1;

    function automatic logic [3:0] model_nzcv(input logic [2:0] op, input logic [2:0] res,
                                              input logic n, input logic z, input logic c,
                                              input logic v, input logic [3:0] cur);
        if (op == 3'd0 || op == 3'd7) return {n, z, c, v};
        return {res[2], (res == 3'd0), cur[1], cur[0]};
    endfunction

    always @(posedge clk) begin
        alu_entry_t e;
        bit         do_pop, do_push;
        logic [3:0] nf;
        if (rst) begin
            mq.delete();
            mflags = 4'h0;
            live   = 1'b1;
            fresh  = 1'b1;
        end else if (live) begin
            do_pop  = (mq.size() != 0) && out_ready;
            do_push = in_valid && (mq.size() != 2);
            nf = in_flag_en ? model_nzcv(in_op, in_result, in_n, in_z, in_c, in_v, mflags) : mflags;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.result = in_result;
                e.flags  = nf;
                mq.push_back(e);
                mflags = nf;
                fresh  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_in_ready", in_ready, (!rst && mq.size() != 2));
            chk("m_out_valid", out_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_out_result", out_result, mq[0].result);
                chk("m_out_flags", out_flags, mq[0].flags);
            end else if (fresh) begin
                chk("m_rst_result", out_result, 0);
                chk("m_rst_flags", out_flags, 0);
            end
            chk("m_flags_q", flags_q, mflags);
            chk("m_carry_fb", carry_fb, mflags[1]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] res, input logic [2:0] op, input logic n,
                        input logic z, input logic c, input logic v, input logic fe);
        in_valid   = 1'b1;
        in_result  = res;
        in_op      = op;
        in_n       = n;
        in_z       = z;
        in_c       = c;
        in_v       = v;
        in_flag_en = fe;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] seq [4];
        seq = '{3'd5, 3'd6, 3'd7, 3'd0};
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_result = '0; in_op = '0;
        in_n = 0; in_z = 0; in_c = 0; in_v = 0; in_flag_en = 0;

        // Reset held two cycles
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", flags_q, 4'b0000);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();

        // ADD accept
        push(3'b000, 3'd0, 0, 1, 1, 0, 1);
        tick(); idle();
        chk("add_valid", out_valid, 1);
        chk("add_result", out_result, 0);
        chk("add_out_flags", out_flags, 4'b0110);
        chk("add_carry_fb", carry_fb, 1);

        // XOR keeps C/V
        push(3'b101, 3'd3, 0, 1, 0, 1, 1);
        tick(); idle();
        chk("xor_flags_q", flags_q, 4'b1010);
        chk("xor_out_flags", out_flags, 4'b1010);
        chk("xor_result", out_result, 3'b101);
        tick();
        chk("xor_drained", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        push(3'd1, 3'd0, 0, 0, 0, 0, 0); tick();
        push(3'd2, 3'd0, 0, 0, 0, 0, 0); tick();
        chk("bp_full_ready", in_ready, 0);
        push(3'd3, 3'd0, 0, 0, 0, 0, 0); tick();
        chk("bp_held_ready", in_ready, 0);
        chk("bp_head1", out_result, 3'd1);
        chk("bp_snapshot", out_flags, 4'b1010);
        out_ready = 1'b1;
        tick();
        chk("bp_head2", out_result, 3'd2);
        chk("bp_ready_again", in_ready, 1);
        tick(); idle();
        chk("bp_head3", out_result, 3'd3);
        tick();
        chk("bp_empty", out_valid, 0);

        // Simultaneous push/pop at count 1
        out_ready = 1'b0;
        push(3'd4, 3'd0, 0, 0, 0, 0, 0); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(seq[i], 3'd0, 0, 0, 0, 0, 0);
            tick();
            chk("pp_in_ready", in_ready, 1);
            chk("pp_valid", out_valid, 1);
            chk("pp_head", out_result, seq[i]);
        end
        idle(); tick();
        chk("pp_empty", out_valid, 0);

        // Back-to-back flag chaining, then a no-update op
        push(3'b100, 3'd0, 1, 0, 0, 1, 1); tick();
        chk("ch_add_flags", out_flags, 4'b1001);
        push(3'b000, 3'd6, 1, 1, 1, 1, 1); tick();
        chk("ch_and_flags", out_flags, 4'b0101);
        push(3'b111, 3'd5, 0, 0, 0, 0, 0); tick(); idle();
        chk("ch_not_result", out_result, 3'b111);
        chk("ch_not_flags", out_flags, 4'b0101);
        chk("ch_carry_fb", carry_fb, 0);
        tick();

        // Reset with a full buffer
        out_ready = 1'b0;
        push(3'd6, 3'd0, 1, 0, 1, 1, 1); tick();
        push(3'd2, 3'd7, 0, 0, 1, 0, 1); tick(); idle();
        chk("mr_full", in_ready, 0);
        chk("mr_flags_pre", flags_q, 4'b0010);
        rst = 1'b1;
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_flags", flags_q, 4'b0000);
        chk("mr_result", out_result, 0);
        chk("mr_carry", carry_fb, 0);
        chk("mr_in_ready", in_ready, 0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk("mr_no_reappear1", out_valid, 0);
        tick();
        chk("mr_no_reappear2", out_valid, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
